pipelined_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit that generalises the team's single-cycle 16-bit carry adder to any width. Operands are split into SEG-bit segments; each pipeline stage resolves one segment and passes its carry to the next, so throughput is one operation per cycle at any width. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure, and sits between operand registers and the datapath result bus.

---
 rtl/pipelined_addsub.sv | 111 +++++++++++
 tb/tb_pipelined_addsub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Segmented, pipelined add/subtract: stage k resolves SEG-bit segment k and hands
// its carry to stage k+1, giving one beat per cycle at any WIDTH with a global stall.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic [STAGES-1:0] vld_pipe_d, vld_pipe_q;
  logic              ovf_d, ovf_q;

  assign out_valid = vld_pipe_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Subtract is a + ~b + !borrow_in, so the segment adders never see the mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~c_in : c_in;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (advance) vld_pipe_d = (vld_pipe_q << 1) | STAGES'(in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      ovf_q      <= 1'b0;
    end else if (advance) begin
      vld_pipe_q <= vld_pipe_d;
      ovf_q      <= ovf_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HI_W = WIDTH - k*SEG;   // operand bits not yet consumed
    logic [HI_W-1:0]      a_i, b_i;
    logic                 c_i;
    logic [SEG:0]         seg_sum;
    logic [(k+1)*SEG-1:0] s_d, s_q;
    logic                 c_d, c_q;

    if (k == 0) begin : g_first
      assign a_i = a;
      assign b_i = b_eff;
      assign c_i = c_eff;
      assign s_d = seg_sum[SEG-1:0];
    end else begin : g_next
      assign a_i = g_stg[k-1].g_hi.ah_q;
      assign b_i = g_stg[k-1].g_hi.bh_q;
      assign c_i = g_stg[k-1].c_q;
      assign s_d = {seg_sum[SEG-1:0], g_stg[k-1].s_q};
    end

    always_comb begin
      seg_sum = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
      c_d     = seg_sum[SEG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    if (k < STAGES-1) begin : g_hi
      logic [HI_W-SEG-1:0] ah_d, ah_q, bh_d, bh_q;
      assign ah_d = a_i[HI_W-1:SEG];
      assign bh_d = b_i[HI_W-1:SEG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ah_q <= '0;
          bh_q <= '0;
        end else if (advance) begin
          ah_q <= ah_d;
          bh_q <= bh_d;
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      assign ovf_d = a_i[SEG-1] ^ b_i[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
    end
  end

  assign sum   = g_stg[STAGES-1].s_q;
  assign c_out = g_stg[STAGES-1].c_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at 32/8, 16/4 and 8/8 (single stage),
// checked against a plain-integer arithmetic model.
module tb_pipelined_addsub;
  typedef struct {
    logic [33:0] res;
    int          cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a_in, b_in;
  logic        ci, sb;
  logic        iv[3], ordy[3], irdy[3], ov[3], co[3], of[3];
  logic [31:0] s32;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] sum_w[3];

  assign sum_w[0] = s32;
  assign sum_w[1] = {16'b0, s16};
  assign sum_w[2] = {24'b0, s8};

  pipelined_addsub #(.WIDTH(32), .SEG(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_in), .b(b_in), .c_in(ci), .sub(sb),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s32), .c_out(co[0]), .ovf(of[0]));

  pipelined_addsub #(.WIDTH(16), .SEG(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_in[15:0]), .b(b_in[15:0]), .c_in(ci), .sub(sb),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s16), .c_out(co[1]), .ovf(of[1]));

  pipelined_addsub #(.WIDTH(8), .SEG(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_in[7:0]), .b(b_in[7:0]), .c_in(ci), .sub(sb),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s8), .c_out(co[2]), .ovf(of[2]));

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   waits = 0;
  int   spur = 0;
  bit   lat_chk = 1'b1;
  bit   bp_mode = 1'b0;
  int   wid[3] = '{32, 16, 8};
  int   stg[3] = '{4, 4, 1};
  exp_t sbq[3][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference: true integer arithmetic; overflow when the signed result leaves range.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, bv,
                                        input logic c, s);
    longint m, ua, ub, sa, sbv, cc, r, sr;
    logic   co_e, of_e;
    m   = longint'(1) << w;
    ua  = longint'(av) & (m - 1);
    ub  = longint'(bv) & (m - 1);
    cc  = longint'(c);
    sa  = (ua >= m/2) ? ua - m : ua;
    sbv = (ub >= m/2) ? ub - m : ub;
    if (!s) begin
      r = ua + ub + cc;  co_e = (r >= m);  sr = sa + sbv + cc;
    end else begin
      r = ua - ub - cc;  co_e = (r >= 0);  sr = sa - sbv - cc;
    end
    of_e = (sr >= m/2) || (sr < -(m/2));
    return {of_e, co_e, 32'(r & (m - 1))};
  endfunction

  always @(negedge clk) ordy[0] = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;

  // Monitor: handshake rule, stall stability, in-order scoreboard, optional latency.
  logic [34:0] last_o[3];
  bit          stalled[3];
  logic [34:0] mon_o;
  exp_t        mon_e;
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) stalled[i] = 1'b0;
      else begin
        mon_o = {ov[i], of[i], co[i], sum_w[i]};
        check($sformatf("in_ready dut%0d", i), 40'(irdy[i]), 40'(!(ov[i] && !ordy[i])));
        if (stalled[i]) check($sformatf("stall_hold dut%0d", i), 40'(mon_o), 40'(last_o[i]));
        stalled[i] = ov[i] && !ordy[i];
        last_o[i]  = mon_o;
        if (ov[i] && ordy[i]) begin
          if (sbq[i].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output dut%0d: got %h, expected no beat", i, mon_o);
          end else begin
            mon_e = sbq[i].pop_front();
            check($sformatf("result dut%0d", i), 40'({of[i], co[i], sum_w[i]}), 40'(mon_e.res));
            if (lat_chk) check($sformatf("latency dut%0d", i), 40'(cyc - mon_e.cap), 40'(stg[i] - 1));
          end
        end
      end
    end
  end

  task automatic send(input int id, input logic [31:0] av, bv, input logic c, s);
    int   g = 0;
    exp_t e;
    a_in = av; b_in = bv; ci = c; sb = s; iv[id] = 1'b1;
    #1;
    while (!irdy[id] && g < 500) begin
      @(negedge clk); #1; g++;
    end
    waits += g;
    if (!irdy[id]) begin
      n_chk++;
      $display("FAIL send_timeout dut%0d: in_ready 0, expected 1 within 500 cycles", id);
    end else begin
      e.res = model(wid[id], av, bv, c, s);
      e.cap = cyc + 1;
      sbq[id].push_back(e);
    end
    @(negedge clk);
    iv[id] = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && g < 300) begin
      @(negedge clk); g++;
    end
    check("drain_empty", 40'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 40'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iv   = '{default: 1'b0};
    ordy = '{default: 1'b1};
    a_in = '0; b_in = '0; ci = 1'b0; sb = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 40'({ov[0], ov[1], ov[2]}), 40'(0));
    check("reset_result", 40'({of[0], co[0], s32}), 40'(0));
    check("reset_in_ready", 40'({irdy[0], irdy[1], irdy[2]}), 40'(3'b111));
    @(negedge clk);
    rst_n = 1'b1;

    // 16/4 boundary vectors: full ripple, signed overflow, borrow cases
    send(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    send(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    send(1, 32'h0005, 32'h0007, 1'b0, 1'b1);
    send(1, 32'h8000, 32'h0001, 1'b0, 1'b1);
    send(1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    send(1, 32'h0000, 32'h0000, 1'b1, 1'b1);
    drain();

    // single-stage unit
    send(2, 32'h00FF, 32'h0001, 1'b0, 1'b0);
    send(2, 32'h0080, 32'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(2, $urandom, $urandom, 1'($urandom), 1'($urandom));
    drain();

    // 32/8 streaming, out_ready held high
    waits = 0;
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    check("stream_no_backpressure", 40'(waits), 40'(0));
    drain();

    // backpressure with random input gaps
    lat_chk = 1'b0;
    bp_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bp_mode = 1'b0;
    drain();

    // asynchronous reset with three beats in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send(0, $urandom, $urandom, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_out", 40'({ov[0], of[0], co[0], s32}), 40'(0));
    check("async_reset_in_ready", 40'(irdy[0]), 40'(1));
    sbq[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk); #2;
      if (ov[0]) spur++;
    end
    check("no_emit_after_reset", 40'(spur), 40'(0));

    send(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send(2, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
